// File: rtl/sha2_stream_core.sv
// Iterative SHA-256/SHA-224 compression core fed with pre-padded 512-bit blocks.
// The message schedule is a 16-word window that slides by UNROLL words per round cycle.
module sha2_stream_core #(
  parameter int UNROLL      = 1,
  parameter bit SUPPORT_224 = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] block,
  input  logic         block_valid,
  input  logic         block_last,
  input  logic         mode,
  output logic         block_ready,
  output logic         busy,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready
);

  // Handshakes: a block (or the digest) transfers on a rising edge where valid and
  // ready are both high; ready never depends on valid, and valid data must stay put until taken.

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE, DONE} state_t;

  state_t       state;
  state_t       state_next;
  logic [31:0]  w [16];
  logic [31:0]  v [8];
  logic [31:0]  h [8];
  logic [31:0]  w_next [16];
  logic [31:0]  v_next [8];
  logic [31:0]  h_sum [8];
  logic [6:0]   cnt;
  logic         first;
  logic         last_q;
  logic         mode_q;
  logic         armed;
  logic         busy_q;
  logic         digest_valid_q;
  logic [255:0] digest_q;
  logic         mode_in;
  logic         accept;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign mode_in      = SUPPORT_224 ? mode : 1'b0;
  // armed keeps block_ready low across reset and raises it on the first edge after.
  assign block_ready  = armed && (state == IDLE);
  assign accept       = block_valid && block_ready;
  assign busy         = busy_q;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;

  // UNROLL rounds per cycle; window words beyond index 15 are generated on the fly.
  always_comb begin
    logic [31:0] ext [16+UNROLL];
    logic [31:0] vr [8];
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = '0;
    t2 = '0;
    for (int i = 0; i < 16; i++) ext[i] = w[i];
    for (int u = 0; u < UNROLL; u++)
      ext[16+u] = ssig1(ext[14+u]) + ext[9+u] + ssig0(ext[1+u]) + ext[u];
    for (int i = 0; i < 8; i++) vr[i] = v[i];
    for (int u = 0; u < UNROLL; u++) begin
      t1 = vr[7] + bsig1(vr[4]) + ((vr[4] & vr[5]) ^ (~vr[4] & vr[6]))
         + K[cnt[5:0] + 6'(u)] + ext[u];
      t2 = bsig0(vr[0]) + ((vr[0] & vr[1]) ^ (vr[0] & vr[2]) ^ (vr[1] & vr[2]));
      vr[7] = vr[6];
      vr[6] = vr[5];
      vr[5] = vr[4];
      vr[4] = vr[3] + t1;
      vr[3] = vr[2];
      vr[2] = vr[1];
      vr[1] = vr[0];
      vr[0] = t1 + t2;
    end
    for (int i = 0; i < 16; i++) w_next[i] = ext[i+UNROLL];
    for (int i = 0; i < 8; i++) v_next[i] = vr[i];
  end

  always_comb begin
    for (int i = 0; i < 8; i++) h_sum[i] = h[i] + v[i];
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ROUND;
      ROUND:   if (cnt == 7'(64 - UNROLL)) state_next = UPDATE;
      UPDATE:  state_next = last_q ? DONE : IDLE;
      DONE:    if (digest_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) w[i] <= 32'h0;
      for (int i = 0; i < 8; i++) begin
        v[i] <= 32'h0;
        h[i] <= IV256[i];
      end
      cnt            <= '0;
      first          <= 1'b1;
      last_q         <= 1'b0;
      mode_q         <= 1'b0;
      armed          <= 1'b0;
      busy_q         <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          for (int i = 0; i < 16; i++) w[i] <= block[511-32*i -: 32];
          last_q <= block_last;
          cnt    <= '0;
          first  <= 1'b0;
          busy_q <= 1'b1;
          // Mode and IV are chosen only by the first block of a message.
          if (first) begin
            mode_q <= mode_in;
            for (int i = 0; i < 8; i++) begin
              h[i] <= mode_in ? IV224[i] : IV256[i];
              v[i] <= mode_in ? IV224[i] : IV256[i];
            end
          end else begin
            for (int i = 0; i < 8; i++) v[i] <= h[i];
          end
        end
        ROUND: begin
          for (int i = 0; i < 16; i++) w[i] <= w_next[i];
          for (int i = 0; i < 8; i++) v[i] <= v_next[i];
          cnt <= cnt + 7'(UNROLL);
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) h[i] <= h_sum[i];
          if (last_q) begin
            digest_q <= {h_sum[0], h_sum[1], h_sum[2], h_sum[3], h_sum[4], h_sum[5], h_sum[6],
                         mode_q ? 32'h0 : h_sum[7]};
            digest_valid_q <= 1'b1;
          end
        end
        DONE: if (digest_ready) begin
          digest_valid_q <= 1'b0;
          first          <= 1'b1;
          busy_q         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_stream_core.sv
// Bench for sha2_stream_core: three instances (UNROLL 1/2/4) checked against known answers
// and a standalone SHA-256/224 model using the recursive message expansion.
module tb_sha2_stream_core;

  localparam int UNR [3] = '{1, 2, 4};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV_256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV_224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

  localparam logic [447:0] TWO_MSG = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {TWO_MSG, 32'h80000000, 32'h0};
  localparam logic [511:0] BLK_TWO2  = {448'h0, 32'h0, 32'h000001c0};

  localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

  logic         clk;
  logic         rst;
  logic [511:0] blk [3];
  logic         bv [3];
  logic         bl [3];
  logic         md [3];
  logic         dr [3];
  logic         br [3];
  logic         bsy [3];
  logic         dv [3];
  logic [255:0] dg [3];

  int n_cmp;
  int n_bad;

  sha2_stream_core #(.UNROLL(1), .SUPPORT_224(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .block(blk[0]), .block_valid(bv[0]), .block_last(bl[0]), .mode(md[0]),
    .block_ready(br[0]), .busy(bsy[0]), .digest(dg[0]), .digest_valid(dv[0]), .digest_ready(dr[0])
  );

  sha2_stream_core #(.UNROLL(2), .SUPPORT_224(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .block(blk[1]), .block_valid(bv[1]), .block_last(bl[1]), .mode(md[1]),
    .block_ready(br[1]), .busy(bsy[1]), .digest(dg[1]), .digest_valid(dv[1]), .digest_ready(dr[1])
  );

  sha2_stream_core #(.UNROLL(4), .SUPPORT_224(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .block(blk[2]), .block_valid(bv[2]), .block_last(bl[2]), .mode(md[2]),
    .block_ready(br[2]), .busy(bsy[2]), .digest(dg[2]), .digest_valid(dv[2]), .digest_ready(dr[2])
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] b);
    logic [31:0] ws [64];
    logic [31:0] hv [8];
    logic [31:0] a, bb, c, dd, e, f, g, hh, t1, t2;
    for (int t = 0; t < 16; t++) ws[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      ws[t] = (rr(ws[t-2], 17) ^ rr(ws[t-2], 19) ^ (ws[t-2] >> 10)) + ws[t-7]
            + (rr(ws[t-15], 7) ^ rr(ws[t-15], 18) ^ (ws[t-15] >> 3)) + ws[t-16];
    for (int i = 0; i < 8; i++) hv[i] = hin[255-32*i -: 32];
    a = hv[0]; bb = hv[1]; c = hv[2]; dd = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; hh = hv[7];
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + ws[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
      hh = g; g = f; f = e; e = dd + t1; dd = c; c = bb; bb = a; a = t1 + t2;
    end
    return {hv[0] + a, hv[1] + bb, hv[2] + c, hv[3] + dd, hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + hh};
  endfunction

  function automatic logic [255:0] ref_digest(input logic [511:0] b0, input logic [511:0] b1,
                                              input logic [511:0] b2, input int nblk, input logic m);
    logic [511:0] bb [3];
    logic [255:0] hs;
    bb[0] = b0; bb[1] = b1; bb[2] = b2;
    hs = m ? IV_224 : IV_256;
    for (int k = 0; k < nblk; k++) hs = ref_compress(hs, bb[k]);
    if (m) hs[31:0] = 32'h0;
    return hs;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_block(input int d, input logic [511:0] b, input logic last, input logic m,
                            output bit ok);
    ok = 1'b0;
    @(negedge clk);
    blk[d] = b; bl[d] = last; md[d] = m; bv[d] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (br[d]) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 bv[d] = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL send_block dut%0d: block_ready never seen within 300 cycles", d);
    end
  endtask

  // Returns the latency in cycles counted from the handshake edge, as in the latency table.
  task automatic wait_digest(input int d, output int lat);
    bit seen;
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (dv[d]) begin
        lat = i + 1;
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL wait_digest dut%0d: digest_valid not seen within 300 cycles", d);
    end
  endtask

  task automatic take_digest(input int d);
    @(negedge clk);
    dr[d] = 1'b1;
    @(posedge clk);
    #1 dr[d] = 1'b0;
    n_cmp++;
    if ({dv[d], bsy[d], br[d]} !== 3'b001) begin
      n_bad++;
      $display("FAIL take_digest dut%0d: {valid,busy,ready}=%b expected 001", d, {dv[d], bsy[d], br[d]});
    end
  endtask

  task automatic hash_msg(input int d, input logic [511:0] b0, input logic [511:0] b1,
                          input logic [511:0] b2, input int nblk, input logic m, input bit toggle,
                          input int gap, output logic [255:0] got, output int lat);
    logic [511:0] bb [3];
    bit ok;
    bb[0] = b0; bb[1] = b1; bb[2] = b2;
    got = '0;
    lat = 0;
    for (int k = 0; k < nblk; k++) begin
      if (k > 0) repeat (gap) @(negedge clk);
      send_block(d, bb[k], (k == nblk - 1), (toggle && k > 0) ? ~m : m, ok);
      if (!ok) return;
    end
    wait_digest(d, lat);
    got = dg[d];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({br[d], bsy[d], dv[d], dg[d]} !== 259'h0) begin
        n_bad++;
        $display("FAIL reset_outputs dut%0d: ready=%b busy=%b valid=%b digest=%h expected all 0",
                 d, br[d], bsy[d], dv[d], dg[d]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (br[d] !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_release_ready dut%0d: block_ready=%b expected 1", d, br[d]);
      end
    end
  endtask

  task automatic test_abc_256();
    logic [255:0] got;
    int lat;
    hash_msg(0, BLK_ABC, '0, '0, 1, 1'b0, 1'b0, 0, got, lat);
    n_cmp++;
    if (got !== D_ABC) begin
      n_bad++; $display("FAIL abc256_digest: got %h expected %h", got, D_ABC);
    end
    n_cmp++;
    if (got !== ref_digest(BLK_ABC, '0, '0, 1, 1'b0)) begin
      n_bad++; $display("FAIL abc256_model: got %h expected %h", got, ref_digest(BLK_ABC, '0, '0, 1, 1'b0));
    end
    n_cmp++;
    if (lat !== 66) begin
      n_bad++; $display("FAIL abc256_latency: got %0d expected 66", lat);
    end
    n_cmp++;
    if (bsy[0] !== 1'b1) begin
      n_bad++; $display("FAIL abc256_busy_in_done: got %b expected 1", bsy[0]);
    end
    take_digest(0);
  endtask

  task automatic test_empty_unroll();
    logic [255:0] got;
    int lat;
    for (int d = 0; d < 3; d++) begin
      hash_msg(d, BLK_EMPTY, '0, '0, 1, 1'b0, 1'b0, 0, got, lat);
      n_cmp++;
      if (got !== D_EMPTY) begin
        n_bad++; $display("FAIL empty_digest dut%0d: got %h expected %h", d, got, D_EMPTY);
      end
      n_cmp++;
      if (lat !== 64 / UNR[d] + 2) begin
        n_bad++; $display("FAIL empty_latency dut%0d: got %0d expected %0d", d, lat, 64 / UNR[d] + 2);
      end
      take_digest(d);
    end
  endtask

  task automatic test_two_block();
    bit ok;
    int bad_rounds;
    int bad_gap;
    int lat;
    bad_rounds = 0;
    bad_gap = 0;
    send_block(0, BLK_TWO1, 1'b0, 1'b0, ok);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (br[0] !== 1'b0 || bsy[0] !== 1'b1) bad_rounds++;
    end
    n_cmp++;
    if (bad_rounds != 0) begin
      n_bad++; $display("FAIL two_block_rounds: %0d cycles with ready high or busy low, expected 0", bad_rounds);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (br[0] !== 1'b1) begin
      n_bad++; $display("FAIL two_block_throughput: block_ready=%b expected 1 one edge after UPDATE", br[0]);
    end
    repeat (5) begin
      @(negedge clk);
      if (bsy[0] !== 1'b1) bad_gap++;
    end
    n_cmp++;
    if (bad_gap != 0) begin
      n_bad++; $display("FAIL two_block_gap_busy: %0d idle cycles with busy low, expected 0", bad_gap);
    end
    send_block(0, BLK_TWO2, 1'b1, 1'b0, ok);
    wait_digest(0, lat);
    n_cmp++;
    if (dg[0] !== D_TWO) begin
      n_bad++; $display("FAIL two_block_digest: got %h expected %h", dg[0], D_TWO);
    end
    n_cmp++;
    if (dg[0] !== ref_digest(BLK_TWO1, BLK_TWO2, '0, 2, 1'b0)) begin
      n_bad++; $display("FAIL two_block_model: got %h expected %h", dg[0], ref_digest(BLK_TWO1, BLK_TWO2, '0, 2, 1'b0));
    end
    take_digest(0);
  endtask

  task automatic test_sha224();
    logic [255:0] got;
    int lat;
    hash_msg(0, BLK_ABC, '0, '0, 1, 1'b1, 1'b0, 0, got, lat);
    n_cmp++;
    if (got !== D_ABC224) begin
      n_bad++; $display("FAIL abc224_digest: got %h expected %h", got, D_ABC224);
    end
    n_cmp++;
    if (got !== ref_digest(BLK_ABC, '0, '0, 1, 1'b1)) begin
      n_bad++; $display("FAIL abc224_model: got %h expected %h", got, ref_digest(BLK_ABC, '0, '0, 1, 1'b1));
    end
    take_digest(0);
    // mode flips to 1 on the second block; the message must remain SHA-256
    hash_msg(0, BLK_TWO1, BLK_TWO2, '0, 2, 1'b0, 1'b1, 2, got, lat);
    n_cmp++;
    if (got !== D_TWO) begin
      n_bad++; $display("FAIL mode_toggle_ignored: got %h expected %h", got, D_TWO);
    end
    take_digest(0);
  endtask

  task automatic test_backpressure();
    logic [255:0] got;
    int lat;
    int bad_hold;
    bad_hold = 0;
    hash_msg(0, BLK_ABC, '0, '0, 1, 1'b0, 1'b0, 0, got, lat);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      blk[0] = rand_block(); bl[0] = 1'b1; bv[0] = 1'b1;
      if (dg[0] !== D_ABC || dv[0] !== 1'b1 || br[0] !== 1'b0) bad_hold++;
    end
    @(negedge clk);
    bv[0] = 1'b0;
    n_cmp++;
    if (bad_hold != 0) begin
      n_bad++; $display("FAIL backpressure_hold: %0d cycles with digest/valid/ready disturbed, expected 0", bad_hold);
    end
    n_cmp++;
    if (dg[0] !== D_ABC || dv[0] !== 1'b1) begin
      n_bad++; $display("FAIL backpressure_end: digest %h valid %b expected %h valid 1", dg[0], dv[0], D_ABC);
    end
    take_digest(0);
    hash_msg(0, BLK_ABC, '0, '0, 1, 1'b0, 1'b0, 0, got, lat);
    n_cmp++;
    if (got !== D_ABC) begin
      n_bad++; $display("FAIL backpressure_rehash: got %h expected %h", got, D_ABC);
    end
    take_digest(0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [255:0] got;
    int lat;
    hash_msg(0, BLK_ABC, '0, '0, 1, 1'b1, 1'b0, 0, got, lat);
    take_digest(0);
    send_block(0, BLK_TWO1, 1'b0, 1'b1, ok);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({br[0], bsy[0], dv[0], dg[0]} !== 259'h0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: ready=%b busy=%b valid=%b digest=%h expected all 0",
               br[0], bsy[0], dv[0], dg[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (br[0] !== 1'b1) begin
      n_bad++; $display("FAIL mid_reset_ready: block_ready=%b expected 1", br[0]);
    end
    hash_msg(0, BLK_ABC, '0, '0, 1, 1'b0, 1'b0, 0, got, lat);
    n_cmp++;
    if (got !== D_ABC) begin
      n_bad++; $display("FAIL mid_reset_rehash: got %h expected %h", got, D_ABC);
    end
    take_digest(0);
  endtask

  task automatic test_random();
    logic [511:0] b0, b1, b2;
    logic [255:0] got, exp;
    int d, nblk, gap, lat;
    logic m;
    bit tog;
    for (int n = 0; n < 12; n++) begin
      d = $urandom_range(0, 2);
      nblk = $urandom_range(1, 3);
      gap = $urandom_range(0, 3);
      m = 1'($urandom_range(0, 1));
      tog = 1'($urandom_range(0, 1));
      b0 = rand_block(); b1 = rand_block(); b2 = rand_block();
      exp = ref_digest(b0, b1, b2, nblk, m);
      hash_msg(d, b0, b1, b2, nblk, m, tog, gap, got, lat);
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL random_digest #%0d dut%0d: got %h expected %h", n, d, got, exp);
      end
      n_cmp++;
      if (lat !== 64 / UNR[d] + 2) begin
        n_bad++; $display("FAIL random_latency #%0d dut%0d: got %0d expected %0d", n, d, lat, 64 / UNR[d] + 2);
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      n_cmp++;
      if (dg[d] !== exp || dv[d] !== 1'b1) begin
        n_bad++; $display("FAIL random_hold #%0d dut%0d: got %h valid %b expected %h valid 1", n, d, dg[d], dv[d], exp);
      end
      take_digest(d);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      blk[d] = '0; bv[d] = 1'b0; bl[d] = 1'b0; md[d] = 1'b0; dr[d] = 1'b0;
    end
    test_reset();
    test_abc_256();
    test_empty_unroll();
    test_two_block();
    test_sha224();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha2_stream_core.md
Name: sha2_stream_core

Overview:
- Iterative SHA-256/SHA-224 compression engine with a streamed, handshaked input of pre-padded 512-bit blocks.
- Supports multi-block messages of unbounded length, selectable rounds-per-cycle unrolling, and a held digest output with its own handshake.
- Sits between the message padder and consumers such as ECDSA or HMAC front-ends.
- The message schedule is a rolling 16-word window; there is no recursive W expansion.

Parameters:
- UNROLL, 1, rounds computed per clock; legal values are 1, 2, 4. The compression phase takes 64/UNROLL cycles.
- SUPPORT_224, 1, when 0 the mode input is ignored and the core is SHA-256 only.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- block  input  512  padded block; word 0 is at [511:480].
- block_valid  input  1  block and block_last are valid.
- block_last  input  1  this block is the final block of the message.
- mode  input  1  0 = SHA-256, 1 = SHA-224. Sampled only on the first block of a message.
- block_ready  output  1  core can accept a block.
- busy  output  1  a message is in progress (first block accepted, digest not yet taken).
- digest  output  256  result. In SHA-224 mode it is {H0..H6, 32'h0}.
- digest_valid  output  1  digest is valid; held until taken.
- digest_ready  input  1  consumer takes the digest.

Behaviour:
- Reset, while rst is 0 at a rising edge:
  - state = IDLE.
  - block_ready = 0 during reset and 1 in the first cycle after.
  - busy = 0, digest_valid = 0, digest = 0.
  - H0..H7 = SHA-256 IV, first = 1, round counter = 0.
  - Reset mid-message abandons the message with no digest produced.
- IDLE:
  - block_ready = 1.
  - On block_valid & block_ready at edge T:
    - Latch the 16 block words into the W window and latch block_last.
    - If first = 1: latch mode, and load H and a..h from the IV of that mode (SHA-224 IV c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4). Otherwise load a..h from H.
    - Go to ROUND with counter = 0 and first = 0.
- ROUND:
  - block_ready = 0; block_valid is ignored.
  - Each cycle applies rounds counter .. counter+UNROLL-1 using K[j] and the W window, then shifts the window by UNROLL.
  - New word: W[j+16] = s1(W[j+14]) + W[j+9] + s0(W[j+1]) + W[j]. All additions are modulo 2^32.
  - counter += UNROLL. After the cycle in which counter becomes 64, go to UPDATE.
- UPDATE (1 cycle):
  - Hi <= Hi + {a..h}i, modulo 2^32.
  - If last: go to DONE and set digest_valid with the digest register loaded from the new H.
  - Else: go to IDLE.
- DONE:
  - digest and digest_valid are stable while digest_ready = 0.
  - On digest_valid & digest_ready: digest_valid is 0 next cycle, first = 1, go to IDLE, busy = 0.
  - block_ready = 0 in DONE, so a new message cannot start until the digest is taken.
- Latency:
  - Block accepted at edge T means rounds occupy T+1 .. T+64/UNROLL, and UPDATE is at T+64/UNROLL+1.
  - digest_valid is high from the cycle after that edge: 66 cycles for UNROLL=1, 34 for UNROLL=2, 18 for UNROLL=4.
  - Block-to-block throughput: the next block can be accepted on the edge after UPDATE, i.e. one block per 64/UNROLL+2 cycles.
- busy:
  - Set on the first block handshake.
  - Cleared on the digest handshake or by reset.
- Mode:
  - A mode change mid-message has no effect.
  - With SUPPORT_224 = 0, mode is treated as 0.
- No X-propagation tricks: every state register has a defined reset or load value. The internal counter is 7 bits and never wraps past 64.

Test Plan:
- SHA-256 of "abc": block 61626380 00000000 ... 00000018, last=1, UNROLL=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with digest_valid rising exactly 66 cycles after the handshake.
- SHA-256 of the empty string: block 80000000 then zeros, length 0 -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855. Repeat with UNROLL=2 and UNROLL=4 and check latencies of 34 and 18 cycles.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (length 0x1c0):
  - Expected digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - Insert 5 idle cycles between the blocks; block_ready must be low during ROUND and busy must stay high throughout.
- SHA-224 of "abc" with mode=1 -> digest 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
  - Toggling mode on a second message's non-first block does not change the result.
- Backpressure and reset:
  - Hold digest_ready=0 for 20 cycles: digest must stay stable and block_valid must be ignored. Then take the digest and run a new "abc" message, which must give the correct digest (first-block IV reload).
  - Assert rst low in the middle of ROUND: all outputs read 0 and block_ready reads 0 in the next cycle, block_ready returns to 1 in the first cycle after rst returns high, and the next message hashes correctly.
